// File: rtl/branch_resolve_buffer_pkg.sv
// Shared definitions for the branch resolve buffer.
//   ROB_QUEUE_BITS : ROB uid width (table depth is 2**ROB_QUEUE_BITS).
//   LOC_*          : field positions inside the branch unit's out_loc word.
//   branch_entry_t : one resolution record {valid, taken, target}.
//   state_e        : top-level control state.
//   loc_is_branch  : true when an out_loc word is a well-formed branch result.
package branch_resolve_buffer_pkg;

  localparam int ROB_QUEUE_BITS = 4;
  localparam int TARGET_W       = 16;
  localparam int LOC_W          = 18;
  localparam int LOC_TAKEN      = 0;
  localparam int LOC_NONMEM     = 17;

  typedef struct packed {
    logic                valid;
    logic                taken;
    logic [TARGET_W-1:0] target;
  } branch_entry_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  // A branch result must carry the non-memory marker and nothing in the
  // bits between it and the taken flag.
  function automatic logic loc_is_branch(input logic [LOC_W-1:0] loc);
    return loc[LOC_NONMEM] && (loc[LOC_NONMEM-1:LOC_TAKEN+1] == '0);
  endfunction

endpackage

// File: rtl/branch_resolve_buffer_if.sv
// Bundle of the branch-unit result bus, the ROB head port and the
// redirect/flush outputs of the branch resolve buffer.
//   master : the environment (branch unit + ROB + fetch), drives in_*/head_*.
//   slave  : the branch resolve buffer itself.
interface branch_resolve_buffer_if #(
  parameter int UID_BITS = branch_resolve_buffer_pkg::ROB_QUEUE_BITS
) ();

  logic                                          in_valid;
  logic [UID_BITS-1:0]                           in_uid;
  logic [branch_resolve_buffer_pkg::TARGET_W-1:0] in_target;
  logic [branch_resolve_buffer_pkg::LOC_W-1:0]    in_loc;
  logic                                          head_valid;
  logic [UID_BITS-1:0]                           head_uid;
  logic                                          head_commit;
  logic                                          head_done;
  logic                                          redirect_valid;
  logic [branch_resolve_buffer_pkg::TARGET_W-1:0] redirect_pc;
  logic                                          flush;
  logic                                          protocol_err;

  modport master (
    output in_valid, in_uid, in_target, in_loc,
    output head_valid, head_uid, head_commit,
    input  head_done, redirect_valid, redirect_pc, flush, protocol_err
  );

  modport slave (
    input  in_valid, in_uid, in_target, in_loc,
    input  head_valid, head_uid, head_commit,
    output head_done, redirect_valid, redirect_pc, flush, protocol_err
  );

endinterface

// File: rtl/branch_resolve_buffer_table.sv
// Direct-mapped per-uid storage of branch resolutions.
//   clk, reset          : clock, synchronous active-high reset (valid bits only).
//   wr_en/wr_uid/...    : write port, sets entry valid with taken/target.
//   clr_en/clr_uid      : clears one valid bit (not-taken retirement).
//   clr_all             : clears every valid bit (taken retirement / flush).
//   rd_uid/rd_entry     : asynchronous read port.
// Priority on valid bits: clr_all > write > single clear, so a same-cycle
// write to a retiring uid survives, but nothing survives a flush.
module branch_resolve_buffer_table
  import branch_resolve_buffer_pkg::*;
#(
  parameter int UID_BITS = ROB_QUEUE_BITS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [UID_BITS-1:0] wr_uid,
  input  logic                wr_taken,
  input  logic [TARGET_W-1:0] wr_target,
  input  logic                clr_en,
  input  logic [UID_BITS-1:0] clr_uid,
  input  logic                clr_all,
  input  logic [UID_BITS-1:0] rd_uid,
  output branch_entry_t       rd_entry
);

  localparam int DEPTH = 1 << UID_BITS;

  logic [DEPTH-1:0]               valid_d, valid_q;
  logic [DEPTH-1:0]               taken_d, taken_q;
  logic [DEPTH-1:0][TARGET_W-1:0] target_d, target_q;

  always_comb begin
    valid_d  = valid_q;
    taken_d  = taken_q;
    target_d = target_q;
    if (clr_en) begin
      valid_d[clr_uid] = 1'b0;
    end
    if (wr_en) begin
      valid_d[wr_uid]  = 1'b1;
      taken_d[wr_uid]  = wr_taken;
      target_d[wr_uid] = wr_target;
    end
    if (clr_all) begin
      valid_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Payload is qualified by valid, so it needs no reset.
  always_ff @(posedge clk) begin
    taken_q  <= taken_d;
    target_q <= target_d;
  end

  always_comb begin
    rd_entry        = '0;
    rd_entry.valid  = valid_q[rd_uid];
    rd_entry.taken  = taken_q[rd_uid];
    rd_entry.target = target_q[rd_uid];
  end

endmodule

// File: rtl/branch_resolve_buffer.sv
// Branch resolve buffer: records branch-unit resolutions per ROB uid, tells
// the ROB when the head branch is resolved, and on retirement of a taken
// branch issues a one-cycle fetch redirect followed by a FLUSH_CYCLES-long
// pipeline flush.
//   clk, reset : clock, synchronous active-high reset.
//   bus        : slave side of branch_resolve_buffer_if
//                (in_* result bus, head_* ROB port, redirect/flush/error outs).
module branch_resolve_buffer
  import branch_resolve_buffer_pkg::*;
#(
  parameter int UID_BITS     = ROB_QUEUE_BITS,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  branch_resolve_buffer_if.slave  bus
);

  localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

  state_e              state_d, state_q;
  logic [3:0]          cnt_d, cnt_q;
  logic                redirect_valid_d, redirect_valid_q;
  logic [TARGET_W-1:0] redirect_pc_d, redirect_pc_q;
  logic                perr_d, perr_q;

  logic                wr_en;
  logic                clr_en;
  logic                clr_all;
  logic                head_done;
  branch_entry_t       head_entry;

  branch_resolve_buffer_table #(
    .UID_BITS (UID_BITS)
  ) u_table (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_uid    (bus.in_uid),
    .wr_taken  (bus.in_loc[LOC_TAKEN]),
    .wr_target (bus.in_target),
    .clr_en    (clr_en),
    .clr_uid   (bus.head_uid),
    .clr_all   (clr_all),
    .rd_uid    (bus.head_uid),
    .rd_entry  (head_entry)
  );

  // Reads registered table state only: a result written this cycle becomes
  // visible to the ROB next cycle.
  assign head_done = (state_q == ST_IDLE) && bus.head_valid && head_entry.valid;

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    perr_d           = perr_q;
    wr_en            = 1'b0;
    clr_en           = 1'b0;
    clr_all          = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          if (loc_is_branch(bus.in_loc)) begin
            wr_en = 1'b1;
          end else begin
            perr_d = 1'b1;
          end
        end
        if (bus.head_commit) begin
          if (head_done) begin
            if (head_entry.taken) begin
              // Everything younger is squashed, including this cycle's write.
              redirect_valid_d = 1'b1;
              redirect_pc_d    = head_entry.target;
              clr_all          = 1'b1;
              state_d          = ST_FLUSH;
              cnt_d            = FLUSH_LAST;
            end else begin
              clr_en = 1'b1;
            end
          end else begin
            perr_d = 1'b1;
          end
        end
      end
      ST_FLUSH: begin
        // Results arriving during the flush belong to squashed work.
        if (cnt_q == 4'd0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      cnt_q            <= 4'd0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      perr_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      perr_q           <= perr_d;
    end
  end

  assign bus.head_done      = head_done;
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.flush          = (state_q == ST_FLUSH);
  assign bus.protocol_err   = perr_q;

endmodule

// File: tb/tb_branch_resolve_buffer.sv
`timescale 1ns/1ps
module tb_branch_resolve_buffer;
  import branch_resolve_buffer_pkg::*;

  localparam int UB = 4;

  logic clk = 1'b0;
  logic rst2;
  logic rst4;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  branch_resolve_buffer_if #(.UID_BITS(UB)) if2 ();
  branch_resolve_buffer_if #(.UID_BITS(UB)) if4 ();

  branch_resolve_buffer #(.UID_BITS(UB), .FLUSH_CYCLES(2)) dut2 (
    .clk(clk), .reset(rst2), .bus(if2.slave));
  branch_resolve_buffer #(.UID_BITS(UB), .FLUSH_CYCLES(4)) dut4 (
    .clk(clk), .reset(rst4), .bus(if4.slave));

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  typedef struct {
    string       name;
    logic        iv;
    logic [3:0]  iu;
    logic [15:0] it;
    logic [17:0] il;
    logic        hv;
    logic [3:0]  hu;
    logic        hc;
    logic        e_hd;
    logic        e_rv;
    logic        e_fl;
    logic        e_pe;
    logic [15:0] e_pc;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input string n, input logic iv, input logic [3:0] iu,
                              input logic [15:0] it, input logic [17:0] il,
                              input logic hv, input logic [3:0] hu, input logic hc,
                              input logic ehd, input logic erv, input logic efl,
                              input logic epe, input logic [15:0] epc);
    vec_t v;
    v.name = n; v.iv = iv; v.iu = iu; v.it = it; v.il = il;
    v.hv = hv; v.hu = hu; v.hc = hc;
    v.e_hd = ehd; v.e_rv = erv; v.e_fl = efl; v.e_pe = epe; v.e_pc = epc;
    vecs.push_back(v);
  endfunction

  // Scoreboard of expected redirects: cycle in which the pulse must appear and its pc.
  typedef struct {
    int          at;
    logic [15:0] pc;
  } sb_t;
  sb_t         sbq[$];
  logic        mdl_taken [16];
  logic [15:0] mdl_tgt   [16];

  always @(negedge clk) begin
    if (if2.redirect_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("unexpected_redirect", 32'd1, 32'd0);
      end else begin
        sb_t e;
        e = sbq.pop_front();
        chk("sb_redirect_cycle", cyc, e.at);
        chk("sb_redirect_pc", {16'd0, if2.redirect_pc}, {16'd0, e.pc});
      end
    end
  end

  task automatic drive4(input logic iv, input logic [3:0] iu, input logic [15:0] it,
                        input logic [17:0] il, input logic hv, input logic [3:0] hu,
                        input logic hc);
    if4.in_valid = iv; if4.in_uid = iu; if4.in_target = it; if4.in_loc = il;
    if4.head_valid = hv; if4.head_uid = hu; if4.head_commit = hc;
  endtask

  initial begin
    int nfl;
    for (int i = 0; i < 16; i++) begin
      mdl_taken[i] = 1'b0;
      mdl_tgt[i]   = 16'h0;
    end
    rst2 = 1'b1; rst4 = 1'b1;
    if2.in_valid = 0; if2.in_uid = 0; if2.in_target = 0; if2.in_loc = 0;
    if2.head_valid = 0; if2.head_uid = 0; if2.head_commit = 0;
    drive4(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst2 = 1'b0; rst4 = 1'b0;

    //   name            iv iu  target    loc        hv hu hc  hd rv fl pe pc
    add("reset_state",    0, 0, 16'h0000, 18'h00000, 0, 0, 0,  0, 0, 0, 0, 16'h0000);
    add("nt_write3",      1, 3, 16'h0040, 18'h20000, 1, 3, 0,  0, 0, 0, 0, 16'h0000);
    add("nt_visible3",    0, 0, 16'h0000, 18'h00000, 1, 3, 0,  1, 0, 0, 0, 16'h0000);
    add("nt_commit3",     0, 0, 16'h0000, 18'h00000, 1, 3, 1,  1, 0, 0, 0, 16'h0000);
    add("nt_after3",      0, 0, 16'h0000, 18'h00000, 1, 3, 0,  0, 0, 0, 0, 16'h0000);
    add("tk_write5",      1, 5, 16'h1234, 18'h20001, 0, 0, 0,  0, 0, 0, 0, 16'h0000);
    add("pre_write6",     1, 6, 16'h0600, 18'h20000, 0, 0, 0,  0, 0, 0, 0, 16'h0000);
    add("pre_write7",     1, 7, 16'h0700, 18'h20001, 1, 6, 0,  1, 0, 0, 0, 16'h0000);
    add("tk_commit5",     0, 0, 16'h0000, 18'h00000, 1, 5, 1,  1, 0, 0, 0, 16'h0000);
    add("tk_n1_wr8",      1, 8, 16'h0800, 18'h20000, 1, 5, 0,  0, 1, 1, 0, 16'h1234);
    add("tk_n2",          0, 0, 16'h0000, 18'h00000, 1, 8, 0,  0, 0, 1, 0, 16'h1234);
    add("tk_n3_uid6",     0, 0, 16'h0000, 18'h00000, 1, 6, 0,  0, 0, 0, 0, 16'h1234);
    add("squash_uid7",    0, 0, 16'h0000, 18'h00000, 1, 7, 0,  0, 0, 0, 0, 16'h1234);
    add("squash_uid8",    0, 0, 16'h0000, 18'h00000, 1, 8, 0,  0, 0, 0, 0, 16'h1234);
    add("squash_uid5",    0, 0, 16'h0000, 18'h00000, 1, 5, 0,  0, 0, 0, 0, 16'h1234);
    add("same_cyc_wr2",   1, 2, 16'h0222, 18'h20000, 1, 2, 0,  0, 0, 0, 0, 16'h1234);
    add("same_cyc_next",  0, 0, 16'h0000, 18'h00000, 1, 2, 0,  1, 0, 0, 0, 16'h1234);
    add("clr_vs_write2",  1, 2, 16'h0333, 18'h20001, 1, 2, 1,  1, 0, 0, 0, 16'h1234);
    add("write_wins2",    1, 4, 16'h0444, 18'h20000, 1, 2, 1,  1, 0, 0, 0, 16'h1234);
    add("tk2_n1",         0, 0, 16'h0000, 18'h00000, 0, 0, 0,  0, 1, 1, 0, 16'h0333);
    add("tk2_commit_fl",  0, 0, 16'h0000, 18'h00000, 1, 2, 1,  0, 0, 1, 0, 16'h0333);
    add("tk2_wr4_squash", 0, 0, 16'h0000, 18'h00000, 1, 4, 0,  0, 0, 0, 0, 16'h0333);
    add("perr_commit9",   0, 0, 16'h0000, 18'h00000, 1, 9, 1,  0, 0, 0, 0, 16'h0333);
    add("perr_set",       0, 0, 16'h0000, 18'h00000, 0, 0, 0,  0, 0, 0, 1, 16'h0333);
    add("perr_badloc",    1,10, 16'h0AAA, 18'h00001, 0, 0, 0,  0, 0, 0, 1, 16'h0333);
    add("badloc_dropped", 0, 0, 16'h0000, 18'h00000, 1,10, 0,  0, 0, 0, 1, 16'h0333);
    add("wr11_after_err", 1,11, 16'h0BBB, 18'h20001, 1,11, 0,  0, 0, 0, 1, 16'h0333);
    add("uid11_visible",  0, 0, 16'h0000, 18'h00000, 1,11, 0,  1, 0, 0, 1, 16'h0333);

    foreach (vecs[k]) begin
      vec_t v;
      v = vecs[k];
      @(posedge clk);
      #1;
      if2.in_valid = v.iv; if2.in_uid = v.iu; if2.in_target = v.it; if2.in_loc = v.il;
      if2.head_valid = v.hv; if2.head_uid = v.hu; if2.head_commit = v.hc;
      // Commit uses the table state before this cycle's write.
      if (v.hc && v.e_hd && mdl_taken[v.hu]) sbq.push_back('{cyc + 1, mdl_tgt[v.hu]});
      if (v.iv && v.il[17] && (v.il[16:1] == 16'h0)) begin
        mdl_taken[v.iu] = v.il[0];
        mdl_tgt[v.iu]   = v.it;
      end
      @(negedge clk);
      chk({v.name, ".head_done"},      {31'd0, if2.head_done},      {31'd0, v.e_hd});
      chk({v.name, ".redirect_valid"}, {31'd0, if2.redirect_valid}, {31'd0, v.e_rv});
      chk({v.name, ".flush"},          {31'd0, if2.flush},          {31'd0, v.e_fl});
      chk({v.name, ".protocol_err"},   {31'd0, if2.protocol_err},   {31'd0, v.e_pe});
      chk({v.name, ".redirect_pc"},    {16'd0, if2.redirect_pc},    {16'd0, v.e_pc});
    end
    @(posedge clk);
    #1 if2.in_valid = 0; if2.head_valid = 0; if2.head_commit = 0;
    @(negedge clk);
    chk("sb_empty", sbq.size(), 32'd0);

    // FLUSH_CYCLES=4: malformed middle loc bits, then reset in the second flush cycle.
    @(posedge clk); #1 drive4(1, 0, 16'h0000, 18'h20003, 0, 0, 0);
    @(posedge clk); #1 drive4(1, 1, 16'h0111, 18'h20001, 0, 0, 0);
    @(negedge clk); chk("f4_perr_midbits", {31'd0, if4.protocol_err}, 32'd1);
    @(posedge clk); #1 drive4(0, 0, 16'h0000, 18'h00000, 1, 1, 1);
    @(negedge clk); chk("f4_head_done1", {31'd0, if4.head_done}, 32'd1);
    @(posedge clk); #1 drive4(0, 0, 16'h0000, 18'h00000, 0, 0, 0);
    @(negedge clk);
    chk("f4_n1_flush", {31'd0, if4.flush}, 32'd1);
    chk("f4_n1_redirect", {31'd0, if4.redirect_valid}, 32'd1);
    chk("f4_n1_pc", {16'd0, if4.redirect_pc}, 32'h0111);
    @(posedge clk); #1 rst4 = 1'b1;
    @(negedge clk);
    chk("f4_n2_flush", {31'd0, if4.flush}, 32'd1);
    chk("f4_n2_redirect", {31'd0, if4.redirect_valid}, 32'd0);
    @(posedge clk); #1 rst4 = 1'b0;
    @(negedge clk);
    chk("f4_rst_flush", {31'd0, if4.flush}, 32'd0);
    chk("f4_rst_redirect", {31'd0, if4.redirect_valid}, 32'd0);
    chk("f4_rst_perr", {31'd0, if4.protocol_err}, 32'd0);
    chk("f4_rst_pc", {16'd0, if4.redirect_pc}, 32'd0);
    for (int u = 0; u < 16; u++) begin
      @(posedge clk); #1 drive4(0, 0, 16'h0000, 18'h00000, 1, 4'(u), 0);
      @(negedge clk); chk($sformatf("f4_rst_empty_uid%0d", u), {31'd0, if4.head_done}, 32'd0);
    end

    // Full-length flush with FLUSH_CYCLES=4.
    @(posedge clk); #1 drive4(1, 1, 16'h0ABC, 18'h20001, 1, 1, 0);
    @(negedge clk); chk("f4_no_bypass", {31'd0, if4.head_done}, 32'd0);
    @(posedge clk); #1 drive4(0, 0, 16'h0000, 18'h00000, 1, 1, 1);
    @(negedge clk); chk("f4_head_done2", {31'd0, if4.head_done}, 32'd1);
    nfl = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1 drive4(0, 0, 16'h0000, 18'h00000, 0, 0, 0);
      @(negedge clk);
      if (if4.flush !== 1'b1) break;
      nfl++;
    end
    chk("f4_flush_len", nfl, 32'd4);
    chk("f4_pc_hold", {16'd0, if4.redirect_pc}, 32'h0ABC);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_resolve_buffer.md
Name: branch_resolve_buffer

Overview:
- Completion-side consumer of the branch functional unit's result interface (has_outgoing, out_uid, result_val, out_loc).
- Captures each branch resolution (taken bit, target) into a per-ROB-uid table.
- When the ROB retires that uid, issues a one-shot PC redirect if the branch was taken, then holds a multi-cycle pipeline flush.
- Sits between the execute stage and the ROB commit/fetch redirect logic.

Parameters:
- UID_BITS, default `ROB_QUEUE_BITS (4): ROB uid width; table depth is 2**UID_BITS.
- FLUSH_CYCLES, default 2: cycles flush stays high after a taken commit; legal range 1..15.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  branch unit has_outgoing.
- in_uid  in  UID_BITS  branch unit out_uid.
- in_target  in  16  branch unit result_val (jump target).
- in_loc  in  18  branch unit out_loc; bit 0 = taken, bit 17 = non-memory marker.
- head_valid  in  1  ROB head entry valid.
- head_uid  in  UID_BITS  ROB head uid.
- head_commit  in  1  ROB retires head this cycle (legal only when head_done=1).
- head_done  out  1  head branch resolved, ROB may retire it.
- redirect_valid  out  1  one-cycle pulse, fetch must load redirect_pc.
- redirect_pc  out  16  redirect target.
- flush  out  1  squash all in-flight younger work.
- protocol_err  out  1  sticky: commit without resolution, or malformed in_loc.

Behaviour:
- Reset (synchronous, active-high): all table valid bits 0, state IDLE, redirect_valid 0, redirect_pc 0, flush 0, protocol_err 0, flush counter 0.
- Table entry fields: valid, taken, target[15:0]; indexed by uid.
- Write: in IDLE, in_valid=1 and in_loc[17]=1 → entry[in_uid] <= {1, in_loc[0], in_target} at the clock edge.
  - in_valid=1 with in_loc[17]=0 or in_loc[16:1]!=0: write dropped, protocol_err set.
  - Rewriting an already-valid entry overwrites it (last write wins).
- head_done is combinational: state==IDLE & head_valid & entry[head_uid].valid. A result written at cycle N is visible at N+1; there is no same-cycle bypass.
- Commit in IDLE with head_commit & head_done:
  - Not taken: entry[head_uid].valid cleared at the edge; no redirect; stay IDLE. A same-cycle write to the same uid wins over the clear.
  - Taken: at N+1, redirect_valid=1 for exactly one cycle and redirect_pc=target (redirect_pc holds its value afterwards). flush=1, all valid bits cleared, including any write in cycle N. State → FLUSH, counter = FLUSH_CYCLES-1.
- head_commit without head_done: ignored, no state change, protocol_err set.
- FLUSH state:
  - flush=1, head_done=0, in_valid writes dropped silently, head_commit ignored with no error.
  - Counter decrements each cycle; when counter==0, next state is IDLE.
  - flush is therefore high for exactly FLUSH_CYCLES cycles (N+1 .. N+FLUSH_CYCLES).
  - Writes are accepted again from cycle N+FLUSH_CYCLES+1.
- Reset asserted mid-FLUSH: next cycle IDLE, flush 0, table empty.
- uid wrap-around: table is direct-mapped, so no wrap logic; the ROB guarantees uid uniqueness among live entries.

Decomposition:
- Shared package (cpu_pkg):
  - UID width constant (mirroring `ROB_QUEUE_BITS).
  - out_loc field positions: LOC_TAKEN=0, LOC_NONMEM=17.
  - branch_entry_t struct {valid, taken, target}.
  - state enum {IDLE, FLUSH}.
- One natural sub-module: branch_resolve_table, holding the valid/taken/target storage with a write port, a clear port, a clear-all input and an async read port. The FSM, counter and redirect register stay in the top.

Test Plan:
- Not-taken commit, FLUSH_CYCLES=2: write uid 3 (in_loc=0x20000, target 0x0040); head_uid=3 → head_done=1 next cycle; commit → redirect_valid stays 0, head_done=0 afterwards.
- Taken commit: write uid 5 (in_loc=0x20001, target 0x1234); commit at cycle N → redirect_valid=1 and redirect_pc=0x1234 at N+1 only; flush=1 at N+1 and N+2, 0 at N+3.
- Flush squash: preload uids 6 and 7 valid, take a taken commit on 5; write uid 8 during FLUSH; afterwards head_uid=6/7/8 → head_done=0 for all.
- Same-cycle write: write uid 2 in the cycle head_uid=2 → head_done=0 that cycle, 1 the next.
- Protocol errors: head_commit with uid 9 unresolved → protocol_err=1 sticky, no redirect. Then in_valid with in_loc=0x00001 → write dropped, error remains 1.
- Reset mid-FLUSH (FLUSH_CYCLES=4) at second flush cycle → next cycle flush=0, redirect_valid=0, protocol_err=0, head_done=0 for all uids.
